// File: rtl/conv_window_accum.sv
// 3x3 window adder tree with per-channel accumulation, bias, saturation and one output per channel group.
// Optional: define CONV_ACCUM_RELU_EN to force negative saturated results to zero.
module conv_window_accum #(
    parameter int dwidth = 16,
    parameter int qwidth = 11,
    parameter int nchan  = 6,
    parameter int awidth = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [dwidth-1:0] p00,
    input  logic signed [dwidth-1:0] p01,
    input  logic signed [dwidth-1:0] p02,
    input  logic signed [dwidth-1:0] p10,
    input  logic signed [dwidth-1:0] p11,
    input  logic signed [dwidth-1:0] p12,
    input  logic signed [dwidth-1:0] p20,
    input  logic signed [dwidth-1:0] p21,
    input  logic signed [dwidth-1:0] p22,
    input  logic signed [dwidth-1:0] bias,
    input  logic                     flush,
    output logic                     sum_valid,
    output logic signed [dwidth-1:0] sum,
    output logic                     sat
);

    localparam int cw = $clog2(nchan + 1);
    localparam logic signed [dwidth-1:0] c_max = {1'b0, {(dwidth-1){1'b1}}};
    localparam logic signed [dwidth-1:0] c_min = {1'b1, {(dwidth-1){1'b0}}};

    // Products are pre-scaled; the fraction width only constrains legal parameter sets.
    if (awidth < dwidth + 4 + $clog2(nchan) || qwidth >= dwidth || nchan < 1 || nchan > 256) begin : g_bad_params
        $error("conv_window_accum: illegal parameter combination");
    end

    typedef enum logic [1:0] {ACC_IDLE, ACC_RUN, ACC_EMIT} acc_state_t;

    function automatic logic signed [awidth-1:0] sext(input logic signed [dwidth-1:0] v);
        return {{(awidth-dwidth){v[dwidth-1]}}, v};
    endfunction

    logic signed [dwidth-1:0] w_p [9];
    logic signed [awidth-1:0] r_x [9];
    logic signed [awidth-1:0] r_a [5];
    logic signed [awidth-1:0] r_b [3];
    logic signed [awidth-1:0] r_c;
    logic                     r_v0, r_v1, r_v2, r_v3;
    logic signed [awidth-1:0] r_acc, r_acc_done, w_acc_next, w_r;
    logic        [cw-1:0]     r_cnt;
    logic                     w_last, w_hi, w_lo;
    logic signed [dwidth-1:0] w_clamped, w_sum;
    acc_state_t               r_state, w_state_next;

    assign w_p = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};

    // Valid bits are cleared by reset and flush; the data registers behind them need no reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v0 <= in_valid;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // NOTE: tree data registers are left unreset on purpose; a stale value is never consumed without its valid bit.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < 9; i++) r_x[i] <= sext(w_p[i]);
        end
        if (r_v0) begin
            r_a[0] <= r_x[0] + r_x[1];
            r_a[1] <= r_x[2] + r_x[3];
            r_a[2] <= r_x[4] + r_x[5];
            r_a[3] <= r_x[6] + r_x[7];
            r_a[4] <= r_x[8];
        end
        if (r_v1) begin
            r_b[0] <= r_a[0] + r_a[1];
            r_b[1] <= r_a[2] + r_a[3];
            r_b[2] <= r_a[4];
        end
        if (r_v2) begin
            r_c <= r_b[0] + r_b[1] + r_b[2];
        end
    end

    assign w_last     = (r_cnt == cw'(nchan - 1));
    assign w_acc_next = (r_cnt == '0) ? r_c : r_acc + r_c;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_v3) begin
            r_acc <= w_acc_next;
            r_cnt <= w_last ? '0 : r_cnt + cw'(1);
        end
    end

    // Snapshot of the finished group so the next group can start accumulating during the emit cycle.
    always_ff @(posedge clk) begin
        if (r_v3 && w_last && !rst && !flush) r_acc_done <= w_acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACC_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (flush)                    w_state_next = ACC_IDLE;
        else if (r_v3)                w_state_next = w_last ? ACC_EMIT : ACC_RUN;
        else if (r_state == ACC_EMIT) w_state_next = ACC_IDLE;
    end

    assign w_r       = r_acc_done + sext(bias);
    assign w_hi      = (w_r > sext(c_max));
    assign w_lo      = (w_r < sext(c_min));
    assign w_clamped = w_hi ? c_max : (w_lo ? c_min : w_r[dwidth-1:0]);
`ifdef CONV_ACCUM_RELU_EN
    assign w_sum     = w_clamped[dwidth-1] ? '0 : w_clamped;
`else
    assign w_sum     = w_clamped;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum       <= '0;
            sat       <= 1'b0;
        end else begin
            sum_valid <= (r_state == ACC_EMIT);
            if (r_state == ACC_EMIT) begin
                sum <= w_sum;
                sat <= w_hi || w_lo;
            end
        end
    end

endmodule
